nonce_search: RTL and testbench
===============================

NONCE_SEARCH -- requirements
Module: nonce_search

Interface
REQ-001 SHALL have parameter SUM_WIDTH, default 13, width of the Adder sum and target.
REQ-002 SHALL have parameter NONCE_WIDTH, default 8, width of nonce and attempt counter.
REQ-003 SHALL have parameter MAX_TRIES, default 200, attempt limit, used only with NONCE_LIMIT_EN.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port go  input  1  search request, sampled only in IDLE, DONE and FAIL.
REQ-007 SHALL have port target  input  SUM_WIDTH  acceptance threshold, latched on accepted go.
REQ-008 SHALL have port fine  input  1  Adder completion flag.
REQ-009 SHALL have port sum_in  input  SUM_WIDTH  Adder result, valid when fine rises.
REQ-010 SHALL have port start  output  1  one-cycle launch pulse to FSM start.
REQ-011 SHALL have port nonce  output  NONCE_WIDTH  current candidate, fed into message.
REQ-012 SHALL have port busy  output  1  high in LAUNCH, WAIT, CHECK.
REQ-013 SHALL have port found  output  1  high in DONE.
REQ-014 SHALL have port fail  output  1  high in FAIL.
REQ-015 SHALL have port found_nonce  output  NONCE_WIDTH  nonce of accepted sum.
REQ-016 SHALL have port found_sum  output  SUM_WIDTH  accepted sum.

Function
REQ-017 SHALL implement states IDLE, LAUNCH, WAIT, CHECK, DONE, FAIL; all outputs registered.
REQ-018 SHALL, on go=1 in IDLE/DONE/FAIL, latch target, clear nonce and attempt counter, clear found/fail, enter LAUNCH.
REQ-019 SHALL ignore go in LAUNCH, WAIT, CHECK.
REQ-020 SHALL hold start=1 for exactly the one cycle spent in LAUNCH, then enter WAIT.
REQ-021 SHALL detect a rising edge of fine (fine=1, previous-cycle fine=0); the edge register updates in every state.
REQ-022 SHALL, in WAIT on a fine rising edge, capture sum_in into an internal register and enter CHECK; a fine level held high from a prior run SHALL NOT trigger.
REQ-023 SHALL, in CHECK, compare unsigned: captured sum <= latched target -> found_nonce=nonce, found_sum=sum, enter DONE.
REQ-024 SHALL, in CHECK on mismatch, increment attempt counter and nonce, then re-enter LAUNCH (next start pulse 1 cycle after CHECK).
REQ-025 SHALL enter FAIL instead of LAUNCH when nonce equals all-ones at mismatch (no wrap to 0 is ever launched).
REQ-026 SHALL hold DONE/FAIL outputs stable until a new go or reset.
REQ-027 SHALL accept target=0 (only sum 0 matches) and target=all-ones (first attempt always matches).

Reset
REQ-028 SHALL, on reset=1 at a clock edge, enter IDLE with start=0, nonce=0, busy=0, found=0, fail=0, found_nonce=0, found_sum=0, counters and edge register 0.
REQ-029 SHALL give reset priority over go and fine; reset mid-search aborts with no pending start pulse.

Configuration
REQ-030 SHALL support macro NONCE_LIMIT_EN: when defined, mismatch with attempt counter reaching MAX_TRIES enters FAIL; when undefined, only REQ-025 ends a failing search (2^NONCE_WIDTH attempts).

Verification
REQ-031 SHALL cover: reset held 2 cycles -> all outputs 0, state IDLE.
REQ-032 SHALL cover: go, target=13'h1FFF, fine rises with sum_in=13'h0ABC -> one start pulse, found=1, found_nonce=0, found_sum=13'h0ABC.
REQ-033 SHALL cover: target=13'h0100, sums 13'h0300, 13'h0200, 13'h00FF on successive fine edges -> 3 start pulses, found_nonce=2, found_sum=13'h00FF.
REQ-034 SHALL cover: target=0, every sum nonzero, macro undefined -> 256 start pulses, fail=1 after nonce=8'hFF; macro defined -> fail=1 after 200 pulses.
REQ-035 SHALL cover: fine held high across LAUNCH -> no capture until fine falls and rises again; go during WAIT -> ignored.
REQ-036 SHALL cover: reset asserted in WAIT -> next cycle IDLE, start=0, nonce=0; subsequent go restarts from nonce 0.

Source files
------------

// File: rtl/nonce_search.sv
// nonce_search: drives an external Adder with successive nonce candidates
// until the returned sum is at or below a latched target.
// Each attempt: one-cycle start pulse, wait for a fresh rising edge of fine,
// capture sum_in, compare. Search ends in DONE on a match, or in FAIL when
// the candidate space is exhausted.
// Optional build macro NONCE_LIMIT_EN: additionally ends a failing search
// after MAX_TRIES attempts.
module nonce_search #(
  parameter int unsigned SUM_WIDTH   = 13,
  parameter int unsigned NONCE_WIDTH = 8,
  parameter int unsigned MAX_TRIES   = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [SUM_WIDTH-1:0]   target,
  input  logic                   fine,
  input  logic [SUM_WIDTH-1:0]   sum_in,
  output logic                   start,
  output logic [NONCE_WIDTH-1:0] nonce,
  output logic                   busy,
  output logic                   found,
  output logic                   fail,
  output logic [NONCE_WIDTH-1:0] found_nonce,
  output logic [SUM_WIDTH-1:0]   found_sum
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

`ifdef NONCE_LIMIT_EN
  localparam bit LIMIT_ACTIVE = 1'b1;
`else
  localparam bit LIMIT_ACTIVE = 1'b0;
`endif

  logic [2:0]             state_reg, state_next;
  logic [NONCE_WIDTH-1:0] nonce_reg, nonce_next;
  logic [NONCE_WIDTH-1:0] attempt_reg, attempt_next;
  logic [SUM_WIDTH-1:0]   target_reg, target_next;
  logic [SUM_WIDTH-1:0]   sum_reg, sum_next;
  logic [NONCE_WIDTH-1:0] found_nonce_reg, found_nonce_next;
  logic [SUM_WIDTH-1:0]   found_sum_reg, found_sum_next;
  logic                   fine_d_reg;
  logic                   start_reg, start_next;
  logic                   busy_reg, busy_next;
  logic                   found_reg, found_next;
  logic                   fail_reg, fail_next;

  logic fine_rise;
  logic last_try;

  // Only a fresh 0->1 transition of fine counts; a level left high from an
  // earlier run never triggers a capture.
  assign fine_rise = fine & ~fine_d_reg;

  // The current attempt is the last one if the candidate space is used up
  // (never wrap back to nonce 0) or, when the limit is built in, the
  // attempt budget is spent. LIMIT_ACTIVE folds the second term away.
  assign last_try = (nonce_reg == {NONCE_WIDTH{1'b1}}) ||
                    (LIMIT_ACTIVE && ((32'(attempt_reg) + 32'd1) >= MAX_TRIES));

  // Next-state and datapath update logic.
  always_comb begin
    state_next       = state_reg;
    nonce_next       = nonce_reg;
    attempt_next     = attempt_reg;
    target_next      = target_reg;
    sum_next         = sum_reg;
    found_nonce_next = found_nonce_reg;
    found_sum_next   = found_sum_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_FAIL: begin
        if (go) begin
          target_next  = target;
          nonce_next   = '0;
          attempt_next = '0;
          state_next   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (fine_rise) begin
          sum_next   = sum_in;
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sum_reg <= target_reg) begin
          found_nonce_next = nonce_reg;
          found_sum_next   = sum_reg;
          state_next       = S_DONE;
        end else if (last_try) begin
          state_next = S_FAIL;
        end else begin
          nonce_next   = nonce_reg + 1'b1;
          attempt_next = attempt_reg + 1'b1;
          state_next   = S_LAUNCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // and line up exactly with the state they describe.
  always_comb begin
    start_next = (state_next == S_LAUNCH);
    busy_next  = (state_next == S_LAUNCH) || (state_next == S_WAIT) ||
                 (state_next == S_CHECK);
    found_next = (state_next == S_DONE);
    fail_next  = (state_next == S_FAIL);
  end

  // State and output registers; reset overrides go and fine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      nonce_reg       <= '0;
      attempt_reg     <= '0;
      target_reg      <= '0;
      sum_reg         <= '0;
      found_nonce_reg <= '0;
      found_sum_reg   <= '0;
      fine_d_reg      <= 1'b0;
      start_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      found_reg       <= 1'b0;
      fail_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      nonce_reg       <= nonce_next;
      attempt_reg     <= attempt_next;
      target_reg      <= target_next;
      sum_reg         <= sum_next;
      found_nonce_reg <= found_nonce_next;
      found_sum_reg   <= found_sum_next;
      fine_d_reg      <= fine;
      start_reg       <= start_next;
      busy_reg        <= busy_next;
      found_reg       <= found_next;
      fail_reg        <= fail_next;
    end
  end

  assign start       = start_reg;
  assign nonce       = nonce_reg;
  assign busy        = busy_reg;
  assign found       = found_reg;
  assign fail        = fail_reg;
  assign found_nonce = found_nonce_reg;
  assign found_sum   = found_sum_reg;

endmodule

// File: tb/tb_nonce_search.sv
// tb_nonce_search: table-driven and randomized checks of nonce_search.
// The bench plays the Adder: on every start pulse it returns a sum taken
// from sum_tab[nonce] after a short delay, as a one-cycle fine pulse.
module tb_nonce_search;

`ifdef NONCE_LIMIT_EN
  localparam int LIMIT = 200;
`else
  localparam int LIMIT = 256;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [12:0] target;
  logic        fine;
  logic [12:0] sum_in;
  logic        start;
  logic [7:0]  nonce;
  logic        busy;
  logic        found;
  logic        fail;
  logic [7:0]  found_nonce;
  logic [12:0] found_sum;

  int tests  = 0;
  int failed = 0;

  logic [12:0] sum_tab [256];

  typedef struct {
    string       name;
    logic [12:0] tgt;
    logic [12:0] s0, s1, s2, fill;
    bit          exp_found;
    logic [7:0]  exp_nonce;
    logic [12:0] exp_sum;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [5];

  nonce_search dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .target     (target),
    .fine       (fine),
    .sum_in     (sum_in),
    .start      (start),
    .nonce      (nonce),
    .busy       (busy),
    .found      (found),
    .fail       (fail),
    .found_nonce(found_nonce),
    .found_sum  (found_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: scan candidates in order, first sum <= target wins,
  // give up after LIMIT attempts.
  task automatic model(input logic [12:0] tgt, output bit ef, output logic [7:0] en,
                       output logic [12:0] es, output int ep);
    ef = 1'b0; en = '0; es = '0; ep = LIMIT;
    for (int i = 0; i < LIMIT; i++) begin
      if (sum_tab[i] <= tgt) begin
        ef = 1'b1; en = 8'(i); es = sum_tab[i]; ep = i + 1;
        break;
      end
    end
  endtask

  // Issue go, answer every start pulse from sum_tab, then check the result.
  task automatic do_search(input string name, input logic [12:0] tgt, input bit ef,
                           input logic [7:0] en, input logic [12:0] es, input int ep);
    int pulses = 0;
    int bad_seq = 0;
    int cyc = 0;
    int d;
    logic [7:0] n;
    target = tgt; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check({name, ".busy_launch"}, busy, 1'b1);
    while (!(found || fail) && cyc < 8000) begin
      if (start) begin
        pulses++;
        n = nonce;
        if (n != 8'(pulses - 1)) bad_seq++;
        d = $urandom_range(1, 3);
        repeat (d) @(negedge clk);
        sum_in = sum_tab[n]; fine = 1'b1;
        @(negedge clk);
        fine = 1'b0;
        cyc += d + 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({name, ".no_timeout"}, (cyc < 8000), 1'b1);
    check({name, ".found"}, found, ef);
    check({name, ".fail"}, fail, !ef);
    check({name, ".pulses"}, pulses, ep);
    check({name, ".nonce_seq_errors"}, bad_seq, 0);
    if (ef) begin
      check({name, ".found_nonce"}, found_nonce, en);
      check({name, ".found_sum"}, found_sum, es);
    end
    repeat (3) @(negedge clk);
    check({name, ".hold_found"}, found, ef);
    check({name, ".hold_busy"}, busy, 1'b0);
    $display("[TB] search %s tgt=%h pulses=%0d found=%0d fail=%0d nonce=%h sum=%h",
             name, tgt, pulses, found, fail, found_nonce, found_sum);
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 256; i++) sum_tab[i] = v.fill;
    sum_tab[0] = v.s0; sum_tab[1] = v.s1; sum_tab[2] = v.s2;
  endtask

  initial begin
    vecs[0] = '{"max_target", 13'h1FFF, 13'h0ABC, 13'h0ABC, 13'h0ABC, 13'h0ABC,
                1'b1, 8'd0, 13'h0ABC, 1};
    vecs[1] = '{"three_tries", 13'h0100, 13'h0300, 13'h0200, 13'h00FF, 13'h1000,
                1'b1, 8'd2, 13'h00FF, 3};
    vecs[2] = '{"zero_target_fail", 13'h0000, 13'h0001, 13'h1FFF, 13'h0002, 13'h0001,
                1'b0, 8'd0, 13'h0000, LIMIT};
    vecs[3] = '{"zero_target_hit", 13'h0000, 13'h0005, 13'h0007, 13'h0000, 13'h0001,
                1'b1, 8'd2, 13'h0000, 3};
    vecs[4] = '{"equal_boundary", 13'h0800, 13'h0801, 13'h0800, 13'h0000, 13'h0001,
                1'b1, 8'd1, 13'h0800, 2};

    reset = 1'b1; go = 1'b0; target = '0; fine = 1'b0; sum_in = '0;

    // Reset held two cycles: everything quiet.
    repeat (2) @(negedge clk);
    check("rst.start", start, 1'b0);
    check("rst.nonce", nonce, 8'd0);
    check("rst.busy", busy, 1'b0);
    check("rst.found", found, 1'b0);
    check("rst.fail", fail, 1'b0);
    check("rst.found_nonce", found_nonce, 8'd0);
    check("rst.found_sum", found_sum, 13'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors.
    for (int i = 0; i < 5; i++) begin
      load_vec(vecs[i]);
      do_search(vecs[i].name, vecs[i].tgt, vecs[i].exp_found, vecs[i].exp_nonce,
                vecs[i].exp_sum, vecs[i].exp_pulses);
    end

    // fine held high across LAUNCH must not capture; go during WAIT ignored.
    target = 13'h1FFF; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("held.start", start, 1'b1);
    fine = 1'b1; sum_in = 13'h0000;
    repeat (3) @(negedge clk);
    check("held.busy", busy, 1'b1);
    check("held.no_capture", found, 1'b0);
    go = 1'b1; target = 13'h0000;
    @(negedge clk);
    go = 1'b0; target = 13'h1FFF;
    check("wait_go.start", start, 1'b0);
    check("wait_go.busy", busy, 1'b1);
    fine = 1'b0;
    @(negedge clk);
    sum_in = 13'h0123; fine = 1'b1;
    @(negedge clk);
    fine = 1'b0;
    repeat (2) @(negedge clk);
    check("held.found", found, 1'b1);
    check("held.found_sum", found_sum, 13'h0123);
    check("held.found_nonce", found_nonce, 8'd0);
    $display("[TB] sequence fine_held/go_in_wait found=%0d sum=%h", found, found_sum);

    // Reset while waiting on the second attempt.
    target = 13'h0000; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    sum_in = 13'h0005; fine = 1'b1;
    @(negedge clk);
    fine = 1'b0;
    @(negedge clk);
    check("rstwait.second_start", start, 1'b1);
    check("rstwait.second_nonce", nonce, 8'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstwait.start", start, 1'b0);
    check("rstwait.nonce", nonce, 8'd0);
    check("rstwait.busy", busy, 1'b0);
    check("rstwait.found", found, 1'b0);
    $display("[TB] sequence reset_in_wait nonce=%h busy=%0d", nonce, busy);
    load_vec(vecs[1]);
    do_search("restart_after_reset", vecs[1].tgt, vecs[1].exp_found, vecs[1].exp_nonce,
              vecs[1].exp_sum, vecs[1].exp_pulses);

    // Randomized searches against the reference model.
    for (int r = 0; r < 8; r++) begin
      logic [12:0] tgt;
      bit ef; logic [7:0] en; logic [12:0] es; int ep;
      for (int i = 0; i < 256; i++) sum_tab[i] = 13'($urandom_range(0, 8191));
      tgt = (r == 7) ? 13'h1FFF : 13'($urandom_range(0, 60));
      model(tgt, ef, en, es, ep);
      do_search($sformatf("rand%0d", r), tgt, ef, en, es, ep);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
